// File: rtl/crypt_decrypt_core.sv
// crypt_decrypt_core: runs BATCHES three-round inverse batches on a 32-bit word, fetching one key triplet per batch
module crypt_decrypt_core #(
    parameter int BATCHES = 32,
    parameter int ROT     = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [31:0] ct_in,
    input  logic [7:0]  k_a,
    input  logic [7:0]  k_b,
    input  logic [7:0]  k_c,
    output logic        ks_en,
    output logic        busy,
    output logic [31:0] pt_out,
    output logic        pt_valid
);
    localparam int CW = $clog2(BATCHES) + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [31:0]   s, s_nx;
    logic [CW-1:0] cnt;
    logic          last;

    function automatic logic [31:0] rnd(input logic [31:0] x, input logic [7:0] k);
        logic [7:0]  t;
        logic [15:0] w;
        t = x[23:16] ^ k;
        w = {t, t} << ROT;
        return {x[23:0], x[31:24] ^ w[15:8]};
    endfunction

    assign s_nx = rnd(rnd(rnd(s, k_c), k_b), k_a);
    assign last = cnt == CW'(BATCHES - 1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? PRIME : IDLE;
            PRIME:   state_nx = RUN;
            RUN:     state_nx = last ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = state != IDLE;
        pt_valid = state == DONE;
        ks_en    = state == PRIME || (state == RUN && !last);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s      <= '0;
            cnt    <= '0;
            pt_out <= '0;
        end else if (state == IDLE && start) begin
            s   <= ct_in;
            cnt <= '0;
        end else if (state == RUN) begin
            s   <= s_nx;
            cnt <= cnt + CW'(1);
            if (last)
                pt_out <= s_nx;
        end
    end
endmodule

// File: doc/crypt_decrypt_core.md
Name: crypt_decrypt_core

Overview:
- Decryption datapath that consumes the round-key byte triplets produced by the decrypt key schedule (K_94/K_95/K_96 outputs).
- Runs BATCHES cycles of three inverse rounds each (96 rounds at default) on a 32-bit ciphertext word.
- Drives the key schedule's en input so exactly one key triplet is fetched per batch.
- Sits between the ciphertext source and the plaintext sink.

Parameters:
- BATCHES, 32, number of 3-round batches per block (1..32).
- ROT, 3, left-rotate amount in the round function (0..7).

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  request to decrypt ct_in; sampled only in IDLE.
- ct_in  input  32  ciphertext word; captured on the accepted start edge.
- k_a  input  8  key byte from key schedule K_94.
- k_b  input  8  key byte from key schedule K_95.
- k_c  input  8  key byte from key schedule K_96.
- ks_en  output  1  enable to the key schedule en port.
- busy  output  1  high in every state except IDLE.
- pt_out  output  32  plaintext; valid while pt_valid is high, held afterwards.
- pt_valid  output  1  one-cycle pulse when pt_out updates.

Behaviour:
- Reset (async, RST_N=0): state=IDLE, state register=0, batch counter=0, ks_en=0, busy=0, pt_out=0, pt_valid=0. Applies immediately, including mid-block; the partial result is discarded.
- Key schedule reset: this block never resets the key schedule. The key schedule updates its outputs one cycle after en is sampled.
- State byte order: x0=S[31:24], x1=S[23:16], x2=S[15:8], x3=S[7:0].
- Round D(S,k) → {x1, x2, x3, x0 ^ rotl8(x1 ^ k, ROT)}.
- Batch: S' = D(D(D(S,k_c),k_b),k_a). Purely combinational within one cycle, key c first.
- States:
  - IDLE: ks_en=0. On start=1, capture ct_in into S, clear counter, go to PRIME.
  - PRIME: ks_en=1 for one cycle so the first triplet is registered by the key schedule; go to RUN.
  - RUN: each cycle, S<=batch(S), counter++. ks_en=1 while counter < BATCHES-1, else 0. When counter reaches BATCHES-1 (last batch applied), load pt_out with the batch result and go to DONE.
  - DONE: pt_valid=1 for exactly one cycle; return to IDLE.
- ks_en handshake: asserted exactly BATCHES times per block (1 in PRIME, BATCHES-1 in RUN). It is never asserted in IDLE or DONE, so the key schedule advances exactly one triplet per batch.
- Latency: start accepted at edge N → pt_valid high in the cycle after edge N+BATCHES+1 (34 edges at default).
- start while busy: ignored, no queuing. start in the DONE cycle is ignored; a new block can be accepted the cycle after DONE.
- Counter: width ceil(log2(BATCHES))+1, no wrap within a block.
- ct_in changes after acceptance have no effect.
- pt_out holds its value until the next DONE or reset.

Test Plan:
- Reset mid-RUN (RST_N low at batch 10) → same cycle: busy=0, ks_en=0, pt_out=0. A new start then completes normally with 34-edge latency.
- BATCHES=1, ROT=3, ct_in=0x01020304, keys all 0 → pt_out=0x04111A23, pt_valid one cycle, ks_en high exactly 1 cycle.
- BATCHES=1, ct_in=0, k_c=0x01, k_b=k_a=0 → pt_out=0x00080000. This confirms key order c,b,a and the rotate.
- Default params, ct_in=0, all keys 0 → pt_out=0x00000000. ks_en high exactly 32 cycles. pt_valid 34 edges after start.
- Default params with the real key schedule attached → pt_out matches the bench's software model. Count of ks_en cycles = 32. Key-schedule count advances by 32.
- start held high continuously → blocks back-to-back with one IDLE cycle between DONE and the next PRIME. start pulses during RUN are ignored (pt_out unchanged until DONE).
